// File: rtl/mem_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : mem_ctrl
// Purpose  : Serves instruction fetches and loads/stores over a byte-wide
//            synchronous RAM, moving one byte per cycle.
// Revision : 1.0
// =====================================================================
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              ifReq_in,
    input  logic [ADDR_W-1:0] ifAddr_in,
    output logic              ifDone_out,
    output logic [31:0]       ifInst_out,
    input  logic              memReq_in,
    input  logic              memWr_in,
    input  logic [1:0]        memSize_in,
    input  logic [ADDR_W-1:0] memAddr_in,
    input  logic [31:0]       memData_in,
    output logic              memDone_out,
    output logic [31:0]       memData_out,
    output logic [ADDR_W-1:0] ramAddr_out,
    output logic              ramWr_out,
    output logic [7:0]        ramData_out,
    input  logic [7:0]        ramData_in
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IF_RD  = 2'd1,
        MEM_RD = 2'd2,
        MEM_WR = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [2:0]        len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rbuf_q, rbuf_d;
    logic              ifDone_q, ifDone_d;
    logic              memDone_q, memDone_d;
    logic [31:0]       ifInst_q, ifInst_d;
    logic [31:0]       memData_q, memData_d;

    logic [1:0]        w_rd_lane;
    logic [31:0]       w_rbuf_ins;
    logic [7:0]        w_wr_byte;
    logic [ADDR_W-1:0] w_cur_addr;
    logic [2:0]        w_mem_len;

    // Read data lags its address by one cycle, so counter value k holds byte k-1.
    assign w_rd_lane  = cnt_q[1:0] - 2'd1;
    assign w_cur_addr = addr_q + ADDR_W'(cnt_q);

    always_comb begin
        w_rbuf_ins = rbuf_q;
        case (w_rd_lane)
            2'd0:    w_rbuf_ins[7:0]   = ramData_in;
            2'd1:    w_rbuf_ins[15:8]  = ramData_in;
            2'd2:    w_rbuf_ins[23:16] = ramData_in;
            default: w_rbuf_ins[31:24] = ramData_in;
        endcase
    end

    always_comb begin
        case (cnt_q[1:0])
            2'd0:    w_wr_byte = wdata_q[7:0];
            2'd1:    w_wr_byte = wdata_q[15:8];
            2'd2:    w_wr_byte = wdata_q[23:16];
            default: w_wr_byte = wdata_q[31:24];
        endcase
    end

    always_comb begin
        case (memSize_in)
            2'd0:    w_mem_len = 3'd1;
            2'd1:    w_mem_len = 3'd2;
            default: w_mem_len = 3'd4;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        ifDone_d    = 1'b0;
        memDone_d   = 1'b0;
        ifInst_d    = ifInst_q;
        memData_d   = memData_q;
        ramAddr_out = '0;
        ramWr_out   = 1'b0;
        ramData_out = 8'h00;

        case (state_q)
            IDLE: begin
                // A pending done pulse blocks acceptance so a held req is not re-served.
                if (!ifDone_q && !memDone_q) begin
                    if (memReq_in) begin
                        addr_d  = memAddr_in;
                        wdata_d = memData_in;
                        len_d   = w_mem_len;
                        cnt_d   = 3'd0;
                        rbuf_d  = 32'h0;
                        state_d = memWr_in ? MEM_WR : MEM_RD;
                    end else if (ifReq_in) begin
                        addr_d  = ifAddr_in;
                        len_d   = 3'd4;
                        cnt_d   = 3'd0;
                        rbuf_d  = 32'h0;
                        state_d = IF_RD;
                    end
                end
            end

            IF_RD, MEM_RD: begin
                if (cnt_q < len_q) begin
                    ramAddr_out = w_cur_addr;
                end
                if (cnt_q != 3'd0) begin
                    rbuf_d = w_rbuf_ins;
                end
                if (cnt_q == len_q) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                    if (state_q == IF_RD) begin
                        ifDone_d = 1'b1;
                        ifInst_d = w_rbuf_ins;
                    end else begin
                        memDone_d = 1'b1;
                        memData_d = w_rbuf_ins;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            MEM_WR: begin
                ramAddr_out = w_cur_addr;
                ramWr_out   = 1'b1;
                ramData_out = w_wr_byte;
                if (cnt_q == len_q - 3'd1) begin
                    state_d   = IDLE;
                    cnt_d     = 3'd0;
                    memDone_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            len_q     <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= 32'h0;
            rbuf_q    <= 32'h0;
            ifDone_q  <= 1'b0;
            memDone_q <= 1'b0;
            ifInst_q  <= 32'h0;
            memData_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rbuf_q    <= rbuf_d;
            ifDone_q  <= ifDone_d;
            memDone_q <= memDone_d;
            ifInst_q  <= ifInst_d;
            memData_q <= memData_d;
        end
    end

    assign ifDone_out  = ifDone_q;
    assign ifInst_out  = ifInst_q;
    assign memDone_out = memDone_q;
    assign memData_out = memData_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// =====================================================================
// Module   : tb_mem_ctrl
// Purpose  : Directed scoreboard bench for mem_ctrl with a byte RAM model.
// Revision : 1.0
// =====================================================================
module tb_mem_ctrl;
    localparam int ADDR_W = 32;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              ifReq_in;
    logic [ADDR_W-1:0] ifAddr_in;
    logic              ifDone_out;
    logic [31:0]       ifInst_out;
    logic              memReq_in;
    logic              memWr_in;
    logic [1:0]        memSize_in;
    logic [ADDR_W-1:0] memAddr_in;
    logic [31:0]       memData_in;
    logic              memDone_out;
    logic [31:0]       memData_out;
    logic [ADDR_W-1:0] ramAddr_out;
    logic              ramWr_out;
    logic [7:0]        ramData_out;
    logic [7:0]        ramData_in;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .ifReq_in    (ifReq_in),
        .ifAddr_in   (ifAddr_in),
        .ifDone_out  (ifDone_out),
        .ifInst_out  (ifInst_out),
        .memReq_in   (memReq_in),
        .memWr_in    (memWr_in),
        .memSize_in  (memSize_in),
        .memAddr_in  (memAddr_in),
        .memData_in  (memData_in),
        .memDone_out (memDone_out),
        .memData_out (memData_out),
        .ramAddr_out (ramAddr_out),
        .ramWr_out   (ramWr_out),
        .ramData_out (ramData_out),
        .ramData_in  (ramData_in)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
        logic              wr;
        logic [7:0]        data;
    } bus_t;

    typedef struct {
        logic        is_if;
        int          cyc;
        logic [31:0] data;
    } done_t;

    bus_t        bus_q[$];
    done_t       done_q[$];
    logic [7:0]  ram [0:1023];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_if;
    logic [31:0] last_mem;
    bus_t        mb;
    done_t       md;

    // Synchronous-read RAM: data for an address appears the following cycle.
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        ramData_in <= ram[ramAddr_out[9:0]];
        if (ramWr_out === 1'b1) ram[ramAddr_out[9:0]] = ramData_out;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (bus_q.size() != 0 && bus_q[0].cyc == cyc) begin
                mb = bus_q.pop_front();
                chk("bus_addr", 64'(ramAddr_out), 64'(mb.addr));
                chk("bus_wr", 64'(ramWr_out), 64'(mb.wr));
                if (mb.wr) chk("bus_wdata", 64'(ramData_out), 64'(mb.data));
            end else begin
                chk("bus_quiet_wr", 64'(ramWr_out), 64'h0);
            end

            if (ifDone_out === 1'b1 || memDone_out === 1'b1) begin
                if (done_q.size() == 0) begin
                    chk("spurious_done", 64'({ifDone_out, memDone_out}), 64'h0);
                end else begin
                    md = done_q.pop_front();
                    chk("done_cycle", 64'(cyc), 64'(md.cyc));
                    chk("done_if", 64'(ifDone_out), 64'(md.is_if));
                    chk("done_mem", 64'(memDone_out), 64'(!md.is_if));
                    chk("done_data", 64'(md.is_if ? ifInst_out : memData_out), 64'(md.data));
                end
            end else if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
                md = done_q.pop_front();
                chk("done_missing_at_cycle", 64'(cyc + 1000), 64'(md.cyc));
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic exp_read(input logic is_if, input int c0, input logic [ADDR_W-1:0] a, input int n);
        logic [31:0] d;
        bus_t        b;
        done_t       e;
        d = 32'h0;
        for (int i = 0; i < n; i++) begin
            b.cyc  = c0 + 1 + i;
            b.addr = a + ADDR_W'(i);
            b.wr   = 1'b0;
            b.data = 8'h00;
            bus_q.push_back(b);
            d[8*i +: 8] = ram[b.addr[9:0]];
        end
        e.is_if = is_if;
        e.cyc   = c0 + n + 2;
        e.data  = d;
        done_q.push_back(e);
        if (is_if) last_if = d;
        else       last_mem = d;
    endtask

    task automatic exp_write(input int c0, input logic [ADDR_W-1:0] a, input int n,
                             input logic [31:0] d, input bit with_done);
        bus_t  b;
        done_t e;
        for (int i = 0; i < n; i++) begin
            b.cyc  = c0 + 1 + i;
            b.addr = a + ADDR_W'(i);
            b.wr   = 1'b1;
            b.data = d[8*i +: 8];
            bus_q.push_back(b);
        end
        if (with_done) begin
            e.is_if = 1'b0;
            e.cyc   = c0 + n + 1;
            e.data  = last_mem;
            done_q.push_back(e);
        end
    endtask

    task automatic mem_op(input logic wr, input logic [1:0] size,
                          input logic [ADDR_W-1:0] a, input logic [31:0] d);
        int c0;
        int n;
        c0 = cyc;
        n  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (wr) exp_write(c0, a, n, d, 1'b1);
        else    exp_read(1'b0, c0, a, n);
        memReq_in  = 1'b1;
        memWr_in   = wr;
        memSize_in = size;
        memAddr_in = a;
        memData_in = d;
        goto(c0 + n + (wr ? 1 : 2) + 1);
        memReq_in = 1'b0;
    endtask

    task automatic if_op(input logic [ADDR_W-1:0] a);
        int c0;
        c0 = cyc;
        exp_read(1'b1, c0, a, 4);
        ifReq_in  = 1'b1;
        ifAddr_in = a;
        goto(c0 + 7);
        ifReq_in = 1'b0;
    endtask

    int         c0;
    logic [7:0] saved;

    initial begin
        rst_in     = 1'b0;
        ifReq_in   = 1'b0;
        ifAddr_in  = '0;
        memReq_in  = 1'b0;
        memWr_in   = 1'b0;
        memSize_in = 2'd0;
        memAddr_in = '0;
        memData_in = 32'h0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'((i * 37 + 11) & 255);
        ram[4] = 8'h13; ram[5] = 8'h00; ram[6] = 8'h00; ram[7] = 8'h00;
        ram[12'h203] = 8'h80;
        last_if  = 32'h0;
        last_mem = 32'h0;

        goto(3);
        chk("rst_ifDone", 64'(ifDone_out), 64'h0);
        chk("rst_ifInst", 64'(ifInst_out), 64'h0);
        chk("rst_memDone", 64'(memDone_out), 64'h0);
        chk("rst_memData", 64'(memData_out), 64'h0);
        chk("rst_ramAddr", 64'(ramAddr_out), 64'h0);
        chk("rst_ramWr", 64'(ramWr_out), 64'h0);
        chk("rst_ramData", 64'(ramData_out), 64'h0);
        rst_in = 1'b1;
        mon_en = 1'b1;
        goto(cyc + 1);

        if_op(32'h4);
        chk("if_0x4_value", 64'(last_if), 64'h13);
        mem_op(1'b1, 2'd2, 32'h100, 32'hDEADBEEF);
        chk("store_word_ram", 64'({ram[12'h103], ram[12'h102], ram[12'h101], ram[12'h100]}), 64'hDEADBEEF);
        mem_op(1'b0, 2'd0, 32'h203, 32'h0);
        chk("load_byte_value", 64'(last_mem), 64'h80);
        mem_op(1'b0, 2'd1, 32'h101, 32'h0);
        chk("load_half_misaligned", 64'(last_mem), 64'hADBE);
        mem_op(1'b0, 2'd3, 32'h100, 32'h0);

        saved = ram[12'h301];
        mem_op(1'b1, 2'd0, 32'h300, 32'hAABBCC55);
        chk("store_byte_ram", 64'(ram[12'h300]), 64'h55);
        chk("store_byte_neighbour", 64'(ram[12'h301]), 64'(saved));
        mem_op(1'b1, 2'd1, 32'h2FF, 32'h99881234);
        mem_op(1'b0, 2'd2, 32'h2FE, 32'h0);
        if_op(32'hFFFF_FFFE);
        chk("hold_ifInst", 64'(ifInst_out), 64'(last_if));
        chk("hold_memData", 64'(memData_out), 64'(last_mem));

        // Both requesters at once: load first, fetch accepted the cycle after its done.
        c0 = cyc;
        exp_read(1'b0, c0, 32'h203, 1);
        exp_read(1'b1, c0 + 4, 32'h4, 4);
        memReq_in = 1'b1; memWr_in = 1'b0; memSize_in = 2'd0; memAddr_in = 32'h203;
        ifReq_in  = 1'b1; ifAddr_in = 32'h4;
        goto(c0 + 4);
        memReq_in = 1'b0;
        goto(c0 + 11);
        ifReq_in = 1'b0;

        // Fetch raised mid-store must wait for the store to finish.
        c0 = cyc;
        exp_write(c0, 32'h180, 4, 32'h11223344, 1'b1);
        exp_read(1'b1, c0 + 6, 32'h8, 4);
        memReq_in = 1'b1; memWr_in = 1'b1; memSize_in = 2'd2;
        memAddr_in = 32'h180; memData_in = 32'h11223344;
        goto(c0 + 2);
        ifReq_in = 1'b1; ifAddr_in = 32'h8;
        goto(c0 + 6);
        memReq_in = 1'b0;
        goto(c0 + 13);
        ifReq_in = 1'b0;
        chk("store_vs_if_ram", 64'({ram[12'h183], ram[12'h182], ram[12'h181], ram[12'h180]}), 64'h11223344);

        // Reset asserted in C3 of a word store.
        saved = ram[12'h203];
        c0 = cyc;
        exp_write(c0, 32'h200, 3, 32'hCAFEF00D, 1'b0);
        memReq_in = 1'b1; memWr_in = 1'b1; memSize_in = 2'd2;
        memAddr_in = 32'h200; memData_in = 32'hCAFEF00D;
        goto(c0 + 3);
        rst_in = 1'b0;
        memReq_in = 1'b0;
        goto(c0 + 4);
        chk("abort_ramWr", 64'(ramWr_out), 64'h0);
        chk("abort_memData", 64'(memData_out), 64'h0);
        chk("abort_ifInst", 64'(ifInst_out), 64'h0);
        last_if  = 32'h0;
        last_mem = 32'h0;
        rst_in = 1'b1;
        goto(c0 + 5);
        chk("abort_ram_written", 64'({ram[12'h202], ram[12'h201], ram[12'h200]}), 64'hFEF00D);
        chk("abort_ram_untouched", 64'(ram[12'h203]), 64'(saved));
        mem_op(1'b0, 2'd2, 32'h200, 32'h0);
        chk("post_reset_load", 64'(last_mem), 64'({saved, 24'hFEF00D}));
        if_op(32'h4);

        goto(cyc + 3);
        chk("bus_queue_drained", 64'(bus_q.size()), 64'h0);
        chk("done_queue_drained", 64'(done_q.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
